// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver driven by an 8x-baud sample tick, with RDRF-style holding register.
//   sys_clk      in   system clock
//   rst          in   asynchronous active-high reset
//   bclkx8       in   oversample clock from the baud generator; each rising edge is one tick
//   rxd          in   serial line, idle high, asynchronous to sys_clk
//   rd_ack       in   one-cycle pulse: host has consumed rx_data
//   rx_data      out  last received byte
//   rx_valid     out  receive register full
//   frame_err    out  stop bit of the byte in rx_data was sampled low
//   overrun_err  out  sticky: a completed byte was dropped because rx_valid was still set
//   busy         out  receiver is inside a frame (state != IDLE)
module uart_rx #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 bclkx8,
   input  logic                 rxd,
   input  logic                 rd_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   bclk_q;
   logic [TW-1:0]          tcnt_q;
   logic [BW-1:0]          bcnt_q;
   logic [DATA_BITS-1:0]   shreg_q;
   logic [DATA_BITS-1:0]   rx_data_q;
   logic                   rx_valid_q;
   logic                   frame_err_q;
   logic                   overrun_q;
   logic                   rxd_s;
   logic                   tick;
   logic                   done;
   assign rxd_s = sync_q[SYNC_STAGES-1];
   assign tick  = bclkx8 & ~bclk_q;
   // the frame completes on the same edge that samples the stop bit
   assign done  = (state_q == STOP) && tick && (tcnt_q == LAST);
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sync_q      <= '1;
         bclk_q      <= 1'b0;
         tcnt_q      <= '0;
         bcnt_q      <= '0;
         shreg_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
         bclk_q <= bclkx8;
         case (state_q)
            IDLE: if (tick && !rxd_s) begin
               state_q <= START;
               tcnt_q  <= TW'(1);
            end
            START: if (tick) begin
               if (tcnt_q == HALF) begin
                  state_q <= rxd_s ? IDLE : DATA;
                  tcnt_q  <= '0;
                  bcnt_q  <= '0;
               end else
                  tcnt_q <= tcnt_q + 1'b1;
            end
            DATA: if (tick) begin
               tcnt_q <= tcnt_q + 1'b1;
               if (tcnt_q == LAST) begin
                  shreg_q <= {rxd_s, shreg_q[DATA_BITS-1:1]};
                  bcnt_q  <= bcnt_q + 1'b1;
                  if (bcnt_q == BLAST) state_q <= STOP;
               end
            end
            STOP: if (tick) begin
               tcnt_q <= tcnt_q + 1'b1;
               if (tcnt_q == LAST) state_q <= rxd_s ? IDLE : BRK;
            end
            // a line held low after a bad stop bit must not start another frame
            BRK: if (rxd_s) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (done) begin
            if (rd_ack || !rx_valid_q) begin
               rx_data_q   <= shreg_q;
               rx_valid_q  <= 1'b1;
               frame_err_q <= ~rxd_s;
               overrun_q   <= overrun_q & ~rd_ack;
            end else
               overrun_q <= 1'b1;
         end else if (rd_ack && rx_valid_q) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
         end
      end
   end
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_q;
   assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx with a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;
   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       bclkx8 = 1'b0;
   logic       rxd = 1'b1;
   logic       rd_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun_err, busy;
   uart_rx dut (
      .sys_clk(sys_clk), .rst(rst), .bclkx8(bclkx8), .rxd(rxd), .rd_ack(rd_ack),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
      .overrun_err(overrun_err), .busy(busy)
   );
   typedef struct packed {logic [7:0] d; logic fe;} exp_t;
   exp_t q[$];
   int   total = 0, bad = 0;
   int   cyc = 0, load_cyc = 0, nloads = 0, start_cyc = 0;
   int   bit_cyc = 80;
   logic sq = 1'b0;
   logic m_full = 1'b0, m_ovr = 1'b0;
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;
   initial forever begin
      if (sq) begin
         #1 bclkx8 = 1'b1;
         repeat (40) @(posedge sys_clk);
         #1 bclkx8 = 1'b0;
         repeat (40) @(posedge sys_clk);
      end else begin
         repeat (9) @(posedge sys_clk);
         #1 bclkx8 = 1'b1;
         @(posedge sys_clk);
         #1 bclkx8 = 1'b0;
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask
   // monitor: a load is rx_valid rising, or rx_valid still high right after an ack
   initial begin
      logic pv, pa;
      exp_t e;
      pv = 1'b0;
      pa = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (rx_valid && (!pv || pa)) begin
            nloads++;
            load_cyc = cyc;
            if (q.size() == 0) chk("unexpected_load", {24'h0, rx_data}, 32'hFFFF_FFFF);
            else begin
               e = q.pop_front();
               chk("rx_data", {24'h0, rx_data}, {24'h0, e.d});
               chk("frame_err", {31'h0, frame_err}, {31'h0, e.fe});
            end
         end
         pv = rx_valid;
         pa = rd_ack;
      end
   end
   initial begin
      #800000;
      $display("FAIL watchdog timeout");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end
   task automatic hold(input logic v, input int n);
      rxd = v;
      repeat (n) @(posedge sys_clk);
      #1;
   endtask
   task automatic send(input logic [7:0] b, input logic stop);
      start_cyc = cyc;
      hold(1'b0, bit_cyc);
      for (int i = 0; i < 8; i++) hold(b[i], bit_cyc);
      hold(stop, bit_cyc);
      rxd = 1'b1;
   endtask
   // reference model of the holding register: a frame loads if the register is
   // empty or the host acknowledges in the completion cycle, otherwise it overruns
   task automatic model_frame(input logic [7:0] b, input logic stop, input logic ack_now);
      if (!m_full || ack_now) begin
         q.push_back('{d: b, fe: ~stop});
         m_full = 1'b1;
         if (ack_now) m_ovr = 1'b0;
      end else
         m_ovr = 1'b1;
   endtask
   task automatic ack();
      rd_ack = 1'b1;
      @(posedge sys_clk);
      #1 rd_ack = 1'b0;
      if (m_full) begin
         m_full = 1'b0;
         m_ovr  = 1'b0;
      end
   endtask
   task automatic chk_state(input string name);
      chk({name, "_valid"}, {31'h0, rx_valid}, {31'h0, m_full});
      chk({name, "_ovr"}, {31'h0, overrun_err}, {31'h0, m_ovr});
   endtask
   task automatic rx_frame(input logic [7:0] b, input logic stop);
      model_frame(b, stop, 1'b0);
      send(b, stop);
   endtask
   initial begin
      int n0;
      logic [7:0] rb;
      logic rs;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("reset_valid", {31'h0, rx_valid}, 32'h0);
      chk("reset_busy", {31'h0, busy}, 32'h0);
      chk("reset_data", {24'h0, rx_data}, 32'h0);
      chk("reset_ovr", {31'h0, overrun_err}, 32'h0);
      rst = 1'b0;
      repeat (5) @(posedge sys_clk);
      #1;
      rx_frame(8'hA5, 1'b1);
      chk("t1_latency_in_window", {31'h0, (load_cyc - start_cyc >= 750) && (load_cyc - start_cyc <= 790)}, 32'h1);
      chk("t1_busy_idle", {31'h0, busy}, 32'h0);
      chk_state("t1");
      ack();
      chk_state("t1_ack");
      hold(1'b0, 20);
      hold(1'b1, 50);
      chk("t2_false_start_busy", {31'h0, busy}, 32'h0);
      chk("t2_no_valid", {31'h0, rx_valid}, 32'h0);
      rx_frame(8'h3C, 1'b1);
      chk_state("t2");
      ack();
      n0 = nloads;
      rx_frame(8'h3C, 1'b0);
      hold(1'b0, 20 * 80);
      chk("t3_break_busy", {31'h0, busy}, 32'h1);
      hold(1'b1, 40);
      chk("t3_break_release", {31'h0, busy}, 32'h0);
      chk("t3_one_load", nloads - n0, 32'h1);
      chk_state("t3");
      ack();
      rx_frame(8'h11, 1'b1);
      rx_frame(8'h22, 1'b1);
      chk("t4_data_kept", {24'h0, rx_data}, 32'h11);
      chk_state("t4");
      ack();
      chk_state("t4_ack");
      rx_frame(8'h11, 1'b1);
      model_frame(8'h22, 1'b1, 1'b1);
      fork
         send(8'h22, 1'b1);
         begin
            int w;
            w = 0;
            while (!busy && w < 200) begin
               @(posedge sys_clk);
               #1 w++;
            end
            chk("t5_start_seen", {31'h0, busy}, 32'h1);
            repeat (759) @(posedge sys_clk);
            #1 rd_ack = 1'b1;
            @(posedge sys_clk);
            #1 rd_ack = 1'b0;
         end
      join
      chk("t5_data", {24'h0, rx_data}, 32'h22);
      chk_state("t5");
      ack();
      for (int i = 0; i < 8; i++) begin
         rb = 8'($urandom);
         rs = $urandom_range(0, 3) != 0;
         rx_frame(rb, rs);
         hold(1'b1, $urandom_range(1, 30));
         chk_state("rand");
         ack();
         chk_state("rand_ack");
      end
      fork
         send(8'hFF, 1'b1);
         begin
            repeat (80 * 4 + 40) @(posedge sys_clk);
            #1 rst = 1'b1;
            #1;
            chk("t6_busy", {31'h0, busy}, 32'h0);
            chk("t6_data", {24'h0, rx_data}, 32'h0);
            chk("t6_flags", {29'h0, rx_valid, frame_err, overrun_err}, 32'h0);
            repeat (20) @(posedge sys_clk);
            #1 rst = 1'b0;
         end
      join
      rx_frame(8'h5A, 1'b1);
      chk_state("t6");
      ack();
      sq = 1'b1;
      bit_cyc = 640;
      hold(1'b1, 200);
      n0 = nloads;
      rx_frame(8'hC3, 1'b1);
      chk("t7_one_load", nloads - n0, 32'h1);
      chk_state("t7");
      ack();
      hold(1'b1, 20);
      chk("sb_empty", q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
